reg_file_sb: RTL

//  Parametrised 2-write / 2-read register file with a per-register busy scoreboard.

---
 rtl/reg_file_sb.sv | 114 +++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// Two-write / two-read register file with a per-register busy scoreboard.
// Port B wins on a same-address write; read ports can forward same-cycle writes.
module reg_file_sb #(
  parameter int DSIZE   = 16,
  parameter int RSIZE   = 4,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_wen_a,
  input  logic [RSIZE-1:0] i_waddr_a,
  input  logic [DSIZE-1:0] i_wdata_a,
  input  logic             i_wen_b,
  input  logic [RSIZE-1:0] i_waddr_b,
  input  logic [DSIZE-1:0] i_wdata_b,
  input  logic             i_issue,
  input  logic [RSIZE-1:0] i_issue_addr,
  input  logic [RSIZE-1:0] i_raddr1,
  input  logic [RSIZE-1:0] i_raddr2,
  output logic [DSIZE-1:0] o_rdata1,
  output logic [DSIZE-1:0] o_rdata2,
  output logic             o_busy1,
  output logic             o_busy2,
  output logic             o_wr_conflict
);

  localparam int NREGS = 2 ** RSIZE;

  logic [DSIZE-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic             r_wr_conflict;

  logic             w_eff_a;
  logic             w_eff_b;
  logic             w_eff_issue;
  logic [NREGS-1:0] w_busy_next;

  assign w_eff_a     = i_wen_a && !(ZERO_R0 && (i_waddr_a == '0));
  assign w_eff_b     = i_wen_b && !(ZERO_R0 && (i_waddr_b == '0));
  assign w_eff_issue = i_issue && !(ZERO_R0 && (i_issue_addr == '0));

  // Set is applied after the clears so a newly issued producer wins over a retiring one.
  always_comb begin
    // NOTE: every variable driven here gets a default first, otherwise a latch is inferred.
    w_busy_next = r_busy;
    if (w_eff_a)     w_busy_next[i_waddr_a]    = 1'b0;
    if (w_eff_b)     w_busy_next[i_waddr_b]    = 1'b0;
    if (w_eff_issue) w_busy_next[i_issue_addr] = 1'b1;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      // NOTE: the array is reset explicitly because readers rely on zeroed registers; this
      // keeps it in flops rather than a RAM macro.
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_busy        <= '0;
      r_wr_conflict <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so the later port-B write takes effect on a clash.
      if (w_eff_a) r_regs[i_waddr_a] <= i_wdata_a;
      if (w_eff_b) r_regs[i_waddr_b] <= i_wdata_b;
      r_busy        <= w_busy_next;
      r_wr_conflict <= w_eff_a && w_eff_b && (i_waddr_a == i_waddr_b);
    end
  end

  function automatic logic [DSIZE-1:0] f_read(
    input logic [RSIZE-1:0] ra,
    input logic [DSIZE-1:0] arr_val,
    input logic             eff_a,
    input logic [RSIZE-1:0] wa,
    input logic [DSIZE-1:0] da,
    input logic             eff_b,
    input logic [RSIZE-1:0] wb,
    input logic [DSIZE-1:0] db
  );
    if (ZERO_R0 && (ra == '0))           return '0;
    else if (BYPASS && eff_b && (wb == ra)) return db;
    else if (BYPASS && eff_a && (wa == ra)) return da;
    else                                 return arr_val;
  endfunction

  // A retiring write hides the busy bit only when no new producer claims the register.
  function automatic logic f_busy(
    input logic [RSIZE-1:0] ra,
    input logic             busy_bit,
    input logic             hit_write,
    input logic             hit_issue
  );
    if (ZERO_R0 && (ra == '0))               return 1'b0;
    else if (BYPASS && hit_write && !hit_issue) return 1'b0;
    else                                     return busy_bit;
  endfunction

  logic w_hit_w1, w_hit_w2, w_hit_i1, w_hit_i2;

  assign w_hit_w1 = (w_eff_a && (i_waddr_a == i_raddr1)) || (w_eff_b && (i_waddr_b == i_raddr1));
  assign w_hit_w2 = (w_eff_a && (i_waddr_a == i_raddr2)) || (w_eff_b && (i_waddr_b == i_raddr2));
  assign w_hit_i1 = w_eff_issue && (i_issue_addr == i_raddr1);
  assign w_hit_i2 = w_eff_issue && (i_issue_addr == i_raddr2);

  always_comb begin
    o_rdata1 = f_read(i_raddr1, r_regs[i_raddr1], w_eff_a, i_waddr_a, i_wdata_a,
                      w_eff_b, i_waddr_b, i_wdata_b);
    o_rdata2 = f_read(i_raddr2, r_regs[i_raddr2], w_eff_a, i_waddr_a, i_wdata_a,
                      w_eff_b, i_waddr_b, i_wdata_b);
    o_busy1  = f_busy(i_raddr1, r_busy[i_raddr1], w_hit_w1, w_hit_i1);
    o_busy2  = f_busy(i_raddr2, r_busy[i_raddr2], w_hit_w2, w_hit_i2);
  end

  assign o_wr_conflict = r_wr_conflict;

endmodule
